// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: entry layout, field slices and default queue depth.
// An entry is packed as {res, rd, rob, pc}, with res in the most significant bits.
`define WB_RES 55:24
`define WB_RD  23:18
`define WB_ROB 17:12
`define WB_PC  11:0

package wb_arbiter_pkg;
  localparam int WB_W          = 56;
  localparam int DEFAULT_DEPTH = 8;
  localparam int NUM_LANES     = 3;
  localparam int NUM_PORTS     = 2;
endpackage

// File: rtl/wb_fifo.sv
// Circular overflow queue: up to 3 pushes and 2 pops per cycle, with the two oldest entries always visible.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [1:0]                 push_n,
  input  logic [WB_W-1:0]            push_d [NUM_LANES],
  input  logic [1:0]                 pop_n,
  output logic [WB_W-1:0]            rd_d [NUM_PORTS],
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WB_W-1:0] mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;

  assign rd_d[0] = mem[head];
  assign rd_d[1] = mem[head + PW'(1)];

  // Storage carries no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!flush && (2'(k) < push_n)) mem[tail + PW'(k)] <= push_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      tail  <= tail + PW'(push_n);
      count <= count - CW'(pop_n) + CW'(push_n);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges three result lanes onto two writeback ports; overflow results wait in an in-order queue.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        valid0,
  input  logic        valid1,
  input  logic        valid2,
  input  logic [31:0] res0,
  input  logic [31:0] res1,
  input  logic [31:0] res2,
  input  logic [5:0]  rd0,
  input  logic [5:0]  rd1,
  input  logic [5:0]  rd2,
  input  logic [5:0]  rob0,
  input  logic [5:0]  rob1,
  input  logic [5:0]  rob2,
  input  logic [11:0] pc0,
  input  logic [11:0] pc1,
  input  logic [11:0] pc2,
  output logic        in_ready,
  output logic        wb_valid0,
  output logic        wb_valid1,
  output logic [31:0] wb_res0,
  output logic [31:0] wb_res1,
  output logic [5:0]  wb_rd0,
  output logic [5:0]  wb_rd1,
  output logic [5:0]  wb_rob0,
  output logic [5:0]  wb_rob1,
  output logic [11:0] wb_pc0,
  output logic [11:0] wb_pc1,
  output logic        overflow
);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]   q_count;
  logic [WB_W-1:0] q_head [NUM_PORTS];
  logic [WB_W-1:0] lane   [NUM_LANES];
  logic [WB_W-1:0] cand   [NUM_LANES];
  logic [WB_W-1:0] push_d [NUM_LANES];
  logic [WB_W-1:0] port_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_v;
  logic [2:0] lane_v;
  logic [2:0] n_lanes, n_pop, n_used;
  logic [1:0] push_n, pop_n;

  assign lane[0] = {res0, rd0, rob0, pc0};
  assign lane[1] = {res1, rd1, rob1, pc1};
  assign lane[2] = {res2, rd2, rob2, pc2};

  assign in_ready = (q_count <= CW'(DEPTH-3));
  assign lane_v   = (in_ready && !flush) ? {valid2, valid1, valid0} : 3'b000;

  // Candidate order: up to two queue heads, then accepted lanes compacted in lane order.
  always_comb begin
    cand    = '{default: '0};
    push_d  = '{default: '0};
    port_d  = '{default: '0};
    port_v  = '0;
    n_lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_v[i]) begin
        for (int s = 0; s < NUM_LANES; s++) begin
          if (n_lanes == 3'(s)) cand[s] = lane[i];
        end
        n_lanes = n_lanes + 3'd1;
      end
    end
    n_pop = (q_count >= CW'(2)) ? 3'd2 : 3'(q_count);
    for (int j = 0; j < NUM_PORTS; j++) begin
      port_v[j] = (3'(j) < (n_pop + n_lanes));
      if (3'(j) < n_pop) begin
        port_d[j] = q_head[j];
      end else begin
        for (int s = 0; s < NUM_LANES; s++) begin
          if ((n_pop + 3'(s)) == 3'(j)) port_d[j] = cand[s];
        end
      end
    end
    n_used = ((3'd2 - n_pop) < n_lanes) ? (3'd2 - n_pop) : n_lanes;
    for (int k = 0; k < NUM_LANES; k++) begin
      for (int s = 0; s < NUM_LANES; s++) begin
        if ((3'(k) + n_used) == 3'(s)) push_d[k] = cand[s];
      end
    end
    push_n = 2'(n_lanes - n_used);
    pop_n  = 2'(n_pop);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .push_n (push_n),
    .push_d (push_d),
    .pop_n  (pop_n),
    .rd_d   (q_head),
    .count  (q_count)
  );

  // Payload registers only load with a valid result, so idle ports keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid0 <= 1'b0;
      wb_valid1 <= 1'b0;
      wb_res0   <= '0;
      wb_res1   <= '0;
      wb_rd0    <= '0;
      wb_rd1    <= '0;
      wb_rob0   <= '0;
      wb_rob1   <= '0;
      wb_pc0    <= '0;
      wb_pc1    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (!flush && !in_ready && (valid0 || valid1 || valid2)) overflow <= 1'b1;
      if (flush) begin
        wb_valid0 <= 1'b0;
        wb_valid1 <= 1'b0;
      end else begin
        wb_valid0 <= port_v[0];
        wb_valid1 <= port_v[1];
        if (port_v[0]) begin
          wb_res0 <= port_d[0][`WB_RES];
          wb_rd0  <= port_d[0][`WB_RD];
          wb_rob0 <= port_d[0][`WB_ROB];
          wb_pc0  <= port_d[0][`WB_PC];
        end
        if (port_v[1]) begin
          wb_res1 <= port_d[1][`WB_RES];
          wb_rd1  <= port_d[1][`WB_RD];
          wb_rob1 <= port_d[1][`WB_ROB];
          wb_pc1  <= port_d[1][`WB_PC];
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: bypass, queueing order, backpressure, overflow, flush and async reset.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
  logic [31:0] res0 = '0, res1 = '0, res2 = '0;
  logic [5:0]  rd0 = '0, rd1 = '0, rd2 = '0;
  logic [5:0]  rob0 = '0, rob1 = '0, rob2 = '0;
  logic [11:0] pc0 = '0, pc1 = '0, pc2 = '0;
  logic        in_ready, wb_valid0, wb_valid1, overflow;
  logic [31:0] wb_res0, wb_res1;
  logic [5:0]  wb_rd0, wb_rd1, wb_rob0, wb_rob1;
  logic [11:0] wb_pc0, wb_pc1;

  int n_vec  = 0;
  int n_miss = 0;
  logic [55:0] exp_q[$];
  logic        saw_63 = 1'b0;

  wb_arbiter #(.DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid0(valid0), .valid1(valid1), .valid2(valid2),
    .res0(res0), .res1(res1), .res2(res2),
    .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .rob0(rob0), .rob1(rob1), .rob2(rob2),
    .pc0(pc0), .pc1(pc1), .pc2(pc2),
    .in_ready(in_ready),
    .wb_valid0(wb_valid0), .wb_valid1(wb_valid1),
    .wb_res0(wb_res0), .wb_res1(wb_res1),
    .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
    .wb_rob0(wb_rob0), .wb_rob1(wb_rob1),
    .wb_pc0(wb_pc0), .wb_pc1(wb_pc1),
    .overflow(overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] mk(input logic [5:0] rob);
    mk = {32'hC000_0000 | {26'h0, rob}, rob ^ 6'h2A, rob, {6'h15, rob}};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lanes(input logic [2:0] v, input logic [5:0] r0, input logic [5:0] r1,
                             input logic [5:0] r2, input bit track);
    logic [55:0] e0, e1, e2;
    e0 = mk(r0); e1 = mk(r1); e2 = mk(r2);
    {valid2, valid1, valid0} = v;
    {res0, rd0, rob0, pc0} = e0;
    {res1, rd1, rob1, pc1} = e1;
    {res2, rd2, rob2, pc2} = e2;
    if (track) begin
      if (v[0]) exp_q.push_back(e0);
      if (v[1]) exp_q.push_back(e1);
      if (v[2]) exp_q.push_back(e2);
    end
  endtask

  task automatic idle_lanes();
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
  endtask

  // scoreboard: every port result must be the next expected result in issue order
  task automatic tick_collect();
    logic [55:0] e;
    tick();
    if (wb_valid0) begin
      if (wb_rob0 == 6'd63) saw_63 = 1'b1;
      if (exp_q.size() == 0) check("spurious0", 64'(wb_valid0), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("order0", 64'({wb_res0, wb_rd0, wb_rob0, wb_pc0}), 64'(e));
      end
    end
    if (wb_valid1) begin
      if (wb_rob1 == 6'd63) saw_63 = 1'b1;
      if (exp_q.size() == 0) check("spurious1", 64'(wb_valid1), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("order1", 64'({wb_res1, wb_rd1, wb_rob1, wb_pc1}), 64'(e));
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      tick_collect();
      budget++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int cycles;
    logic [5:0] r;

    // reset state
    #12;
    check("rst_v0", 64'(wb_valid0), 64'd0);
    check("rst_v1", 64'(wb_valid1), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_res0", 64'(wb_res0), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single lane 0 result passes straight through
    valid0 = 1'b1; res0 = 32'hA5A5_A5A5; rd0 = 6'd5; rob0 = 6'd3; pc0 = 12'h010;
    tick();
    idle_lanes();
    check("single_v0", 64'(wb_valid0), 64'd1);
    check("single_res", 64'(wb_res0), 64'hA5A5_A5A5);
    check("single_rd", 64'(wb_rd0), 64'd5);
    check("single_rob", 64'(wb_rob0), 64'd3);
    check("single_pc", 64'(wb_pc0), 64'h010);
    check("single_v1", 64'(wb_valid1), 64'd0);
    tick();
    check("hold_v0", 64'(wb_valid0), 64'd0);
    check("hold_res0", 64'(wb_res0), 64'hA5A5_A5A5);

    // three lanes on an empty queue: third result lands one cycle later
    drive_lanes(3'b111, 6'd1, 6'd2, 6'd3, 1'b0);
    tick();
    idle_lanes();
    check("three_v0", 64'(wb_valid0), 64'd1);
    check("three_rob0", 64'(wb_rob0), 64'd1);
    check("three_v1", 64'(wb_valid1), 64'd1);
    check("three_rob1", 64'(wb_rob1), 64'd2);
    check("three_cnt1", 64'(u_dut.q_count), 64'd1);
    tick();
    check("three_v0b", 64'(wb_valid0), 64'd1);
    check("three_rob0b", 64'(wb_rob0), 64'd3);
    check("three_v1b", 64'(wb_valid1), 64'd0);
    check("three_cnt0", 64'(u_dut.q_count), 64'd0);

    // lanes 1 and 2 bypass in lane order
    drive_lanes(3'b110, 6'd0, 6'd7, 6'd8, 1'b0);
    tick();
    idle_lanes();
    check("byp_rob0", 64'(wb_rob0), 64'd7);
    check("byp_rob1", 64'(wb_rob1), 64'd8);
    check("byp_pc1", 64'(wb_pc1), 64'({6'h15, 6'd8}));
    check("byp_cnt", 64'(u_dut.q_count), 64'd0);

    // sustained three-lane traffic until backpressure
    r = 6'd10;
    cycles = 0;
    while (in_ready && cycles < 20) begin
      drive_lanes(3'b111, r, r + 6'd1, r + 6'd2, 1'b1);
      r = r + 6'd3;
      tick_collect();
      cycles++;
    end
    idle_lanes();
    check("bp_cycles", 64'(cycles), 64'd6);
    check("bp_cnt", 64'(u_dut.q_count), 64'd6);
    check("bp_rdy", 64'(in_ready), 64'd0);
    drain();
    check("bp_cnt_end", 64'(u_dut.q_count), 64'd0);
    check("bp_ovf", 64'(overflow), 64'd0);

    // a result offered while not ready is dropped and latches overflow
    r = 6'd30;
    cycles = 0;
    while (in_ready && cycles < 20) begin
      drive_lanes(3'b111, r, r + 6'd1, r + 6'd2, 1'b1);
      r = r + 6'd3;
      tick_collect();
      cycles++;
    end
    drive_lanes(3'b010, 6'd0, 6'd63, 6'd0, 1'b0);
    tick_collect();
    idle_lanes();
    check("ovf_set", 64'(overflow), 64'd1);
    drain();
    tick_collect();
    tick_collect();
    check("ovf_drop", 64'(saw_63), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // reset clears overflow; then flush a four-entry queue with lanes active
    rst_n = 1'b0;
    #2;
    check("ovf_rst", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_lanes(3'b111, 6'(40 + 3 * i), 6'(41 + 3 * i), 6'(42 + 3 * i), 1'b1);
      tick_collect();
    end
    check("fl_cnt4", 64'(u_dut.q_count), 64'd4);
    flush = 1'b1;
    drive_lanes(3'b111, 6'd60, 6'd61, 6'd62, 1'b0);
    tick();
    flush = 1'b0;
    idle_lanes();
    exp_q.delete();
    check("fl_cnt0", 64'(u_dut.q_count), 64'd0);
    check("fl_v0", 64'(wb_valid0), 64'd0);
    check("fl_v1", 64'(wb_valid1), 64'd0);
    check("fl_ovf", 64'(overflow), 64'd0);
    tick();
    check("fl_quiet", 64'(wb_valid0), 64'd0);

    // asynchronous reset between edges with five queued entries
    for (int i = 0; i < 5; i++) begin
      drive_lanes(3'b111, 6'(3 * i), 6'(3 * i + 1), 6'(3 * i + 2), 1'b1);
      tick_collect();
    end
    idle_lanes();
    check("ar_cnt5", 64'(u_dut.q_count), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("ar_v0", 64'(wb_valid0), 64'd0);
    check("ar_v1", 64'(wb_valid1), 64'd0);
    check("ar_res0", 64'(wb_res0), 64'd0);
    check("ar_rob1", 64'(wb_rob1), 64'd0);
    check("ar_cnt", 64'(u_dut.q_count), 64'd0);
    check("ar_rdy", 64'(in_ready), 64'd1);
    #2;
    rst_n = 1'b1;
    tick();
    check("ar_rdy_post", 64'(in_ready), 64'd1);
    check("ar_v0_post", 64'(wb_valid0), 64'd0);
    drive_lanes(3'b001, 6'd9, 6'd0, 6'd0, 1'b1);
    tick_collect();
    idle_lanes();
    check("ar_resume_v0", 64'(wb_valid0), 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, overflow queue entries; power of two, minimum 4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  mispredict/recovery; discards all buffered and in-flight results.
REQ-005 valid0/valid1/valid2  input  1 each  result lane i carries a completed result this cycle.
REQ-006 res0/res1/res2  input  32 each  result data, lane i.
REQ-007 rd0/rd1/rd2  input  6 each  physical destination register, lane i.
REQ-008 rob0/rob1/rob2  input  6 each  ROB index, lane i.
REQ-009 pc0/pc1/pc2  input  12 each  instruction PC, lane i.
REQ-010 in_ready  output  1  lanes may present valid results this cycle.
REQ-011 wb_valid0/wb_valid1  output  1 each  writeback port j carries a result.
REQ-012 wb_res0/wb_res1  output  32 each  writeback data, port j.
REQ-013 wb_rd0/wb_rd1, wb_rob0/wb_rob1  output  6 each  destination register and ROB index, port j.
REQ-014 wb_pc0/wb_pc1  output  12 each  PC, port j.
REQ-015 overflow  output  1  sticky error: valid result arrived while in_ready=0.

Function
REQ-016 Each cycle the block SHALL form an ordered candidate list: queued entries oldest-first, then valid input lanes in order 0,1,2.
REQ-017 The first two candidates SHALL be registered onto writeback ports 0 then 1, one-cycle latency; unused ports get wb_valid=0.
REQ-018 Remaining candidates SHALL stay in, or be appended to, the queue preserving candidate order; up to 2 pops and 3 pushes per cycle.
REQ-019 A queued entry SHALL always be written back before any result arriving in a later cycle.
REQ-020 in_ready SHALL be combinational from the registered count: 1 iff count <= DEPTH-3.
REQ-021 Valid lanes arriving while in_ready=0 SHALL be dropped and SHALL set overflow; overflow clears only on reset.
REQ-022 Queue head/tail pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH and never exceeds DEPTH.
REQ-023 flush=1 SHALL, at the next edge, empty the queue (count=0), drive both wb_valid=0, and drop all same-cycle inputs without setting overflow.
REQ-024 With an empty queue and at most 2 valid lanes, results SHALL bypass the queue directly to ports in lane order.
REQ-025 wb_res/wb_rd/wb_rob/wb_pc SHALL hold their previous values when the corresponding wb_valid=0.

Reset
REQ-026 On rst_n=0, asynchronously: count, pointers, overflow, wb_valid0/1 = 0; all wb_res/wb_rd/wb_rob/wb_pc = 0.
REQ-027 Release of reset mid-stream SHALL leave the block empty, with in_ready=1 in the first cycle after release.

Structure
REQ-028 The shared constants header SHALL hold WB entry width (56 = 32+6+6+12), field slice macros (WB_RES, WB_RD, WB_ROB, WB_PC) and default DEPTH.
REQ-029 The queue SHALL be a sub-module wb_fifo: circular buffer, 3 write ports, 2 read ports, and a count output.

Verification
REQ-030 Reset, then valid0 only (res=0xA5A5A5A5, rd=5, rob=3, pc=0x010) -> next cycle wb_valid0=1 with those values, wb_valid1=0.
REQ-031 Empty queue, all 3 lanes valid (rob 1,2,3) -> cycle+1 ports hold rob 1,2; cycle+2 port0 holds rob 3; count returns to 0.
REQ-032 3 valid lanes on consecutive cycles until in_ready=0 -> in_ready deasserts when count=6 (DEPTH=8); writeback order strictly matches ROB issue order.
REQ-033 Force valid1=1 while in_ready=0 -> result never appears at any port; overflow=1 and stays 1 until reset.
REQ-034 Queue holding 4 entries, flush=1 with 3 valid lanes -> next cycle count=0, both wb_valid=0, overflow unchanged.
REQ-035 Assert rst_n=0 asynchronously between edges with queue at count 5 -> all outputs reach reset values immediately; in_ready=1 after release.
